// File: rtl/imem_arbiter.sv
// imem_arbiter: owns the single-port instruction memory and shares it between
// the fetch stage (reads) and the program loader / debug port (writes).
// After reset a boot FSM stalls fetch until the loader signals completion.
// From then on, fetch has priority, and a starvation guard lets the loader win
// one grant after STARVE_LIMIT consecutive losses.
// Optional feature: define IMEM_ARB_MISALIGN_CHK_EN to turn a misaligned fetch
// into a NOP return and to set a sticky o_misalign_err flag.
module imem_arbiter #(
    parameter int INSTR_WIDTH  = 32,
    parameter int IMEM_DEPTH   = 256,
    parameter int ADDR_WIDTH   = $clog2(IMEM_DEPTH) + 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_fetch_req,
    input  logic [ADDR_WIDTH-1:0]  i_fetch_addr,
    output logic                   o_fetch_gnt,
    output logic                   o_fetch_rvalid,
    output logic [INSTR_WIDTH-1:0] o_fetch_rdata,
    output logic                   o_fetch_stall,
    input  logic                   i_ld_valid,
    input  logic [ADDR_WIDTH-1:0]  i_ld_addr,
    input  logic [INSTR_WIDTH-1:0] i_ld_data,
    output logic                   o_ld_ready,
    input  logic                   i_ld_done,
    output logic                   o_boot_done,
    output logic                   o_misalign_err,
    output logic                   o_mem_en,
    output logic                   o_mem_we,
    output logic [ADDR_WIDTH-3:0]  o_mem_addr,
    output logic [INSTR_WIDTH-1:0] o_mem_wdata,
    input  logic [INSTR_WIDTH-1:0] i_mem_rdata
);

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(32'h0000_0013);
    localparam logic [3:0]             STARVE_MAX  = 4'(STARVE_LIMIT);

    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } state_t;

    state_t                 state;
    logic [3:0]             starve_cnt;
    logic                   contend;
    logic                   starved;
    logic                   fetch_gnt;
    logic                   ld_gnt;
    logic                   fetch_misalign;
    logic                   rvalid_p1;
    logic                   nop_p1;
    logic [INSTR_WIDTH-1:0] ret_data;
    logic [INSTR_WIDTH-1:0] rdata_hold;
    logic                   unused_addr_bits;

    // Byte-offset bits never select a word; collected here so they are visibly unused.
    assign unused_addr_bits = ^{i_ld_addr[1:0], i_fetch_addr[1:0]};

    // Grant decision: boot gives the port to the loader only; run gives fetch
    // priority except when the loader has lost STARVE_LIMIT cycles in a row.
    always_comb begin
        contend   = i_fetch_req & i_ld_valid;
        starved   = (starve_cnt == STARVE_MAX);
        fetch_gnt = 1'b0;
        ld_gnt    = 1'b0;
        if (state == ST_BOOT) begin
            ld_gnt = i_ld_valid;
        end else begin
            fetch_gnt = i_fetch_req & ~(i_ld_valid & starved);
            ld_gnt    = i_ld_valid & ~fetch_gnt;
        end
    end

`ifdef IMEM_ARB_MISALIGN_CHK_EN
    assign fetch_misalign = fetch_gnt & (i_fetch_addr[1:0] != 2'b00);
`else
    assign fetch_misalign = 1'b0;
`endif

    // Memory port drive and requester-facing handshakes.
    always_comb begin
        o_fetch_gnt   = fetch_gnt;
        o_ld_ready    = ld_gnt;
        o_fetch_stall = (state == ST_BOOT) | (i_fetch_req & ~fetch_gnt);
        o_mem_en      = ld_gnt | (fetch_gnt & ~fetch_misalign);
        o_mem_we      = ld_gnt;
        o_mem_addr    = ld_gnt ? i_ld_addr[ADDR_WIDTH-1:2] : i_fetch_addr[ADDR_WIDTH-1:2];
        o_mem_wdata   = i_ld_data;
    end

    // Boot/run FSM with the registered boot flag and the loader starvation counter.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state       <= ST_BOOT;
            o_boot_done <= 1'b0;
            starve_cnt  <= 4'd0;
        end else begin
            case (state)
                ST_BOOT: begin
                    starve_cnt <= 4'd0;
                    if (i_ld_done) begin
                        state       <= ST_RUN;
                        o_boot_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (contend & ~starved) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end else begin
                        starve_cnt <= 4'd0;
                    end
                end
                default: begin
                    state       <= ST_BOOT;
                    o_boot_done <= 1'b0;
                    starve_cnt  <= 4'd0;
                end
            endcase
        end
    end

    // ---- stage p1: read return, one cycle after the fetch grant ----
    assign ret_data       = nop_p1 ? NOP_INSTR : i_mem_rdata;
    assign o_fetch_rvalid = rvalid_p1;
    assign o_fetch_rdata  = rvalid_p1 ? ret_data : rdata_hold;

    // Track the in-flight read and keep the last returned word visible between reads.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rvalid_p1  <= 1'b0;
            nop_p1     <= 1'b0;
            rdata_hold <= '0;
        end else begin
            rvalid_p1 <= fetch_gnt;
            nop_p1    <= fetch_misalign;
            if (rvalid_p1) begin
                rdata_hold <= ret_data;
            end
        end
    end

`ifdef IMEM_ARB_MISALIGN_CHK_EN
    // Sticky misaligned-fetch flag, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_misalign_err <= 1'b0;
        end else if (fetch_misalign) begin
            o_misalign_err <= 1'b1;
        end
    end
`else
    assign o_misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed testbench for imem_arbiter: a word-addressed memory model behind the
// port, a behavioural reference checked every cycle, and literal expectations.
module tb_imem_arbiter;

    localparam int INSTR_WIDTH  = 32;
    localparam int IMEM_DEPTH   = 256;
    localparam int ADDR_WIDTH   = $clog2(IMEM_DEPTH) + 2;
    localparam int STARVE_LIMIT = 4;
`ifdef IMEM_ARB_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   fetch_req;
    logic [ADDR_WIDTH-1:0]  fetch_addr;
    logic                   fetch_gnt;
    logic                   fetch_rvalid;
    logic [INSTR_WIDTH-1:0] fetch_rdata;
    logic                   fetch_stall;
    logic                   ld_valid;
    logic [ADDR_WIDTH-1:0]  ld_addr;
    logic [INSTR_WIDTH-1:0] ld_data;
    logic                   ld_ready;
    logic                   ld_done;
    logic                   boot_done;
    logic                   misalign_err;
    logic                   mem_en;
    logic                   mem_we;
    logic [ADDR_WIDTH-3:0]  mem_addr;
    logic [INSTR_WIDTH-1:0] mem_wdata;
    logic [INSTR_WIDTH-1:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    imem_arbiter #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .IMEM_DEPTH  (IMEM_DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_fetch_req   (fetch_req),
        .i_fetch_addr  (fetch_addr),
        .o_fetch_gnt   (fetch_gnt),
        .o_fetch_rvalid(fetch_rvalid),
        .o_fetch_rdata (fetch_rdata),
        .o_fetch_stall (fetch_stall),
        .i_ld_valid    (ld_valid),
        .i_ld_addr     (ld_addr),
        .i_ld_data     (ld_data),
        .o_ld_ready    (ld_ready),
        .i_ld_done     (ld_done),
        .o_boot_done   (boot_done),
        .o_misalign_err(misalign_err),
        .o_mem_en      (mem_en),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory with a registered read, as attached to the arbiter.
    logic [INSTR_WIDTH-1:0] mem [IMEM_DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    logic [31:0] ref_mem [IMEM_DEPTH];
    bit          m_run;
    int          m_lost;      // consecutive cycles the loader has lost to fetch
    bit          m_pend;      // a read was issued last cycle
    bit          m_pend_nop;
    logic [31:0] m_pend_data;
    logic [31:0] m_last;
    bit          m_err;
    bit          e_fgnt, e_lgnt, e_mis;

    function automatic int word_of(input logic [ADDR_WIDTH-1:0] a);
        return (int'(a) / 4) % IMEM_DEPTH;
    endfunction

    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        @(posedge clk);
        m_run = 0; m_lost = 0; m_pend = 0; m_pend_nop = 0; m_pend_data = 0; m_last = 0; m_err = 0;
        forever begin
            @(negedge clk);
            e_fgnt = 0;
            e_lgnt = 0;
            if (!m_run) begin
                e_lgnt = ld_valid;
            end else if (fetch_req && ld_valid) begin
                if (m_lost == STARVE_LIMIT) e_lgnt = 1;
                else                        e_fgnt = 1;
            end else begin
                e_fgnt = fetch_req;
                e_lgnt = ld_valid;
            end
            e_mis = MIS_EN && e_fgnt && (fetch_addr % 4 != 0);
            check("gnt",       32'(fetch_gnt),    32'(e_fgnt));
            check("ready",     32'(ld_ready),     32'(e_lgnt));
            check("stall",     32'(fetch_stall),  32'(!m_run || (fetch_req && !e_fgnt)));
            check("mem_en",    32'(mem_en),       32'(e_lgnt || (e_fgnt && !e_mis)));
            check("mem_we",    32'(mem_we),       32'(e_lgnt));
            check("mem_wdata", mem_wdata,         ld_data);
            if (e_lgnt)
                check("mem_addr_ld", 32'(mem_addr), 32'(word_of(ld_addr)));
            else if (e_fgnt && !e_mis)
                check("mem_addr_f",  32'(mem_addr), 32'(word_of(fetch_addr)));
            check("rvalid",    32'(fetch_rvalid), 32'(m_pend));
            check("rdata",     fetch_rdata,       m_pend ? (m_pend_nop ? 32'h13 : m_pend_data) : m_last);
            check("boot_done", 32'(boot_done),    32'(m_run));
            check("mis_err",   32'(misalign_err), 32'(m_err));
            @(posedge clk);
            if (e_lgnt) ref_mem[word_of(ld_addr)] = ld_data;
            if (!reset_n) begin
                m_run = 0; m_lost = 0; m_pend = 0; m_pend_nop = 0; m_last = 0; m_err = 0;
            end else begin
                if (m_pend) m_last = m_pend_nop ? 32'h13 : m_pend_data;
                m_pend      = e_fgnt;
                m_pend_nop  = e_mis;
                m_pend_data = ref_mem[word_of(fetch_addr)];
                if (e_mis) m_err = 1;
                if (m_run) begin
                    if (fetch_req && ld_valid) m_lost = (m_lost == STARVE_LIMIT) ? 0 : m_lost + 1;
                    else                       m_lost = 0;
                end
                if (!m_run && ld_done) m_run = 1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] wide_addr;
        reset_n = 0; fetch_req = 0; fetch_addr = '0; ld_valid = 0; ld_addr = '0; ld_data = '0; ld_done = 0;
        step(); step();
        @(negedge clk);
        check("rst_rvalid", 32'(fetch_rvalid), 32'd0);
        check("rst_rdata",  fetch_rdata,       32'd0);
        check("rst_boot",   32'(boot_done),    32'd0);
        check("rst_stall",  32'(fetch_stall),  32'd1);
        check("rst_err",    32'(misalign_err), 32'd0);
        step();
        reset_n = 1;

        // Boot load with fetch requesting throughout; done with the second write.
        fetch_req = 1; fetch_addr = '0;
        ld_valid = 1; ld_addr = 10'h0; ld_data = 32'h1111_1111;
        @(negedge clk);
        check("boot_gnt0",   32'(fetch_gnt),   32'd0);
        check("boot_stall0", 32'(fetch_stall), 32'd1);
        check("boot_rdy0",   32'(ld_ready),    32'd1);
        step();
        ld_addr = 10'h4; ld_data = 32'h2222_2222; ld_done = 1;
        @(negedge clk);
        check("boot_gnt1",   32'(fetch_gnt),   32'd0);
        check("boot_rdy1",   32'(ld_ready),    32'd1);
        step();
        ld_valid = 0; ld_done = 0; fetch_req = 0;
        @(negedge clk);
        check("boot_done", 32'(boot_done), 32'd1);

        // Fetch read of 0x4.
        step();
        fetch_req = 1; fetch_addr = 10'h4;
        @(negedge clk);
        check("rd_gnt",   32'(fetch_gnt),   32'd1);
        check("rd_stall", 32'(fetch_stall), 32'd0);
        step();
        fetch_req = 0;
        @(negedge clk);
        check("rd_rvalid", 32'(fetch_rvalid), 32'd1);
        check("rd_rdata",  fetch_rdata,       32'h2222_2222);

        // Starvation: both held high, fetch wins 4 then loader wins 1.
        step();
        fetch_req = 1; fetch_addr = 10'h0; ld_valid = 1; ld_addr = 10'h8;
        for (int i = 0; i < 10; i++) begin
            ld_data = 32'h5000_0000 + 32'(i);
            @(negedge clk);
            check("starve_gnt",   32'(fetch_gnt),   (i % 5 == 4) ? 32'd0 : 32'd1);
            check("starve_stall", 32'(fetch_stall), (i % 5 == 4) ? 32'd1 : 32'd0);
            step();
        end
        fetch_req = 0; ld_valid = 0;

        // Wrap: byte address 0x400 lands on word 0.
        step();
        wide_addr = 32'h0000_0400;
        ld_valid = 1; ld_addr = wide_addr[ADDR_WIDTH-1:0]; ld_data = 32'hAAAA_5555;
        @(negedge clk);
        check("wrap_addr", 32'(mem_addr), 32'd0);
        check("wrap_we",   32'(mem_we),   32'd1);
        step();
        ld_valid = 0; fetch_req = 1; fetch_addr = 10'h0;
        step();
        fetch_req = 0;
        @(negedge clk);
        check("wrap_rdata", fetch_rdata, 32'hAAAA_5555);

        // Misaligned fetch at 0x6.
        step();
        fetch_req = 1; fetch_addr = 10'h6;
        @(negedge clk);
        check("mis_en", 32'(mem_en), MIS_EN ? 32'd0 : 32'd1);
        step();
        fetch_req = 0;
        @(negedge clk);
        check("mis_rdata", fetch_rdata,       MIS_EN ? 32'h0000_0013 : 32'h2222_2222);
        check("mis_err1",  32'(misalign_err), MIS_EN ? 32'd1 : 32'd0);
        step(); step();
        @(negedge clk);
        check("mis_err2",  32'(misalign_err), MIS_EN ? 32'd1 : 32'd0);

        // Reset the cycle after a fetch grant.
        step();
        fetch_req = 1; fetch_addr = 10'h4;
        step();
        reset_n = 0; fetch_req = 0;
        step();
        reset_n = 1; fetch_req = 1;
        @(negedge clk);
        check("rr_rvalid", 32'(fetch_rvalid), 32'd0);
        check("rr_boot",   32'(boot_done),    32'd0);
        check("rr_gnt",    32'(fetch_gnt),    32'd0);
        check("rr_stall",  32'(fetch_stall),  32'd1);
        check("rr_err",    32'(misalign_err), 32'd0);

        // Re-enter RUN without reloading: memory contents survive reset.
        ld_done = 1;
        step();
        ld_done = 0;
        @(negedge clk);
        check("rr_gnt2", 32'(fetch_gnt), 32'd1);
        step();
        fetch_req = 0;
        @(negedge clk);
        check("rr_rdata", fetch_rdata, 32'h2222_2222);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
